// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer with shared memory port and watchdog.
// Optional JAL/JALR dispatch is enabled by defining MC_CTRL_JUMP_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam logic [3:0] S_BOOT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4;
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_RD = 4'd6;
    localparam logic [3:0] S_MEM_WR = 4'd7;
    localparam logic [3:0] S_WB_ALU = 4'd8;
    localparam logic [3:0] S_WB_MEM = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JAL    = 4'd11;
    localparam logic [3:0] S_JALR   = 4'd12;
    localparam logic [3:0] S_ERR    = 4'd13;

    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_wait;
    logic             w_timeout;

    logic w_op_r;
    logic w_op_i;
    logic w_op_ld;
    logic w_op_st;
    logic w_op_br;
    logic w_op_jal;
    logic w_op_jalr;

    assign w_op_r  = (opcode == 7'b0110011);
    assign w_op_i  = (opcode == 7'b0010011);
    assign w_op_ld = (opcode == 7'b0000011);
    assign w_op_st = (opcode == 7'b0100011);
    assign w_op_br = (opcode == 7'b1100011);
`ifdef MC_CTRL_JUMP_EN
    assign w_op_jal  = (opcode == 7'b1101111);
    assign w_op_jalr = (opcode == 7'b1100111);
`else
    assign w_op_jal  = 1'b0;
    assign w_op_jalr = 1'b0;
`endif

    // Wait states share the watchdog; the last allowed count aborts unless ready
    assign w_wait = (r_state == S_FETCH) ||
                    (r_state == S_MEM_RD) ||
                    (r_state == S_MEM_WR);
    assign w_timeout = w_wait && !mem_ready && (r_wd_cnt == LP_TO_LAST);

    assign state = r_state;

    // State register; reset forces BOOT so every output drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    // Watchdog: clear on state change or completion, count stalled wait cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if ((w_next != r_state) || mem_ready) begin
            r_wd_cnt <= '0;
        end else if (w_wait) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Output decode and next-state selection
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                unique case (1'b1)
                    w_op_r:            w_next = S_EXEC_R;
                    w_op_i:            w_next = S_EXEC_I;
                    w_op_ld, w_op_st:  w_next = S_ADDR;
                    w_op_br:           w_next = S_BRANCH;
                    w_op_jal:          w_next = S_JAL;
                    w_op_jalr:         w_next = S_JALR;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                w_next    = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                w_next    = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                w_next    = w_op_st ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                pc_write   = zero;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
`ifdef MC_CTRL_JUMP_EN
            S_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
`endif
            S_ERR: begin
                bus_err = 1'b1;
                w_next  = S_ERR;
            end
            default: begin
                w_next = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of sequencing, watchdog and reset.
// Expectations for opcode 1101111 follow MC_CTRL_JUMP_EN.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_err;
    logic [3:0] state;

    int total;
    int bad;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .illegal_op(illegal_op),
        .bus_err(bus_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] all_out;
    assign all_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                      alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
                      instr_done, illegal_op, bus_err};

    logic [5:0] alu_sel;
    assign alu_sel = {alu_src_a, alu_src_b, alu_op};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        opcode = 7'h00;
        zero = 1'b0;
        mem_ready = 1'b0;

        // reset state
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(all_out), 32'd0);
        cyc();
        chk("rst_hold", 32'(state), 32'd0);

        // R-type, zero wait
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        #1;
        chk("boot_state", 32'(state), 32'd0);
        cyc();
        chk("r_fetch", 32'(state), 32'd1);
        chk("r_fetch_ctl",
            32'({mem_req, iord, ir_write, pc_write, pc_src, alu_sel}),
            32'({1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 6'b00_01_00}));
        chk("r_fetch_rw", 32'(reg_write), 32'd0);
        cyc();
        chk("r_decode", 32'(state), 32'd2);
        chk("r_decode_alu", 32'(alu_sel), 32'(6'b10_10_00));
        chk("r_decode_rw", 32'({reg_write, instr_done}), 32'd0);
        cyc();
        chk("r_exec", 32'(state), 32'd3);
        chk("r_exec_alu", 32'(alu_sel), 32'(6'b01_00_10));
        chk("r_exec_rw", 32'({reg_write, instr_done}), 32'd0);
        cyc();
        chk("r_wb", 32'(state), 32'd8);
        chk("r_wb_ctl", 32'({reg_write, mem_to_reg, instr_done}),
            32'(4'b1_00_1));
        cyc();
        chk("r_next", 32'(state), 32'd1);
        chk("r_next_done", 32'({reg_write, instr_done}), 32'd0);

        // load with 3 stalled cycles in MEM_RD
        opcode = 7'b0000011;
        cyc();
        chk("ld_decode", 32'(state), 32'd2);
        cyc();
        chk("ld_addr", 32'(state), 32'd5);
        chk("ld_addr_alu", 32'(alu_sel), 32'(6'b01_10_00));
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("ld_memrd%0d", i), 32'(state), 32'd6);
            chk($sformatf("ld_req%0d", i),
                32'({mem_req, iord, mem_we, reg_write}), 32'(4'b1100));
        end
        mem_ready = 1'b1;
        cyc();
        chk("ld_wbmem", 32'(state), 32'd9);
        chk("ld_wb_ctl", 32'({reg_write, mem_to_reg, instr_done}),
            32'(4'b1_01_1));
        cyc();
        chk("ld_next", 32'(state), 32'd1);

        // branch taken
        opcode = 7'b1100011;
        zero = 1'b1;
        cyc();
        chk("bt_decode", 32'(state), 32'd2);
        cyc();
        chk("bt_branch", 32'(state), 32'd10);
        chk("bt_ctl", 32'({pc_write, pc_src, instr_done, alu_sel}),
            32'({1'b1, 2'b01, 1'b1, 6'b01_00_01}));
        cyc();
        chk("bt_next", 32'(state), 32'd1);

        // branch not taken
        zero = 1'b0;
        cyc();
        cyc();
        chk("bn_branch", 32'(state), 32'd10);
        chk("bn_ctl", 32'({pc_write, instr_done}), 32'(2'b01));
        cyc();
        chk("bn_next", 32'(state), 32'd1);

        // illegal opcode
        opcode = 7'b1111111;
        cyc();
        chk("ill_decode", 32'(state), 32'd2);
        chk("ill_ctl",
            32'({illegal_op, reg_write, pc_write, mem_we, instr_done}),
            32'(5'b10000));
        cyc();
        chk("ill_next", 32'(state), 32'd1);
        chk("ill_pulse", 32'(illegal_op), 32'd0);

        // JAL opcode
        opcode = 7'b1101111;
        cyc();
`ifdef MC_CTRL_JUMP_EN
        chk("jal_decode", 32'(illegal_op), 32'd0);
        cyc();
        chk("jal_state", 32'(state), 32'd11);
        chk("jal_ctl",
            32'({reg_write, mem_to_reg, pc_write, pc_src, instr_done}),
            32'(7'b1_10_1_01_1));
`else
        chk("jal_illegal", 32'(illegal_op), 32'd1);
`endif
        cyc();
        chk("jal_next", 32'(state), 32'd1);

        // store, zero wait
        opcode = 7'b0100011;
        cyc();
        cyc();
        chk("st_addr", 32'(state), 32'd5);
        cyc();
        chk("st_memwr", 32'(state), 32'd7);
        chk("st_ctl", 32'({mem_req, mem_we, iord, instr_done}),
            32'(4'b1111));
        cyc();
        chk("st_next", 32'(state), 32'd1);

        // store stalled, then reset mid-access
        cyc();
        cyc();
        mem_ready = 1'b0;
        cyc();
        chk("sr_memwr", 32'(state), 32'd7);
        chk("sr_req", 32'({mem_req, mem_we, instr_done}), 32'(3'b110));
        #2;
        rst_n = 1'b0;
        #1;
        chk("sr_state", 32'(state), 32'd0);
        chk("sr_outs", 32'(all_out), 32'd0);

        // watchdog abort in FETCH
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_fetch%0d", i), 32'(state), 32'd1);
            chk($sformatf("to_err%0d", i), 32'(bus_err), 32'd0);
            cyc();
        end
        chk("to_errstate", 32'(state), 32'd13);
        chk("to_errouts", 32'(all_out), 32'd1);
        mem_ready = 1'b1;
        cyc();
        chk("to_sticky", 32'(state), 32'd13);
        chk("to_sticky_be", 32'(bus_err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("to_rst_be", 32'(bus_err), 32'd0);

        // ready on the last allowed cycle wins
        mem_ready = 1'b0;
        opcode = 7'b0010011;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lw_fetch%0d", i), 32'(state), 32'd1);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_fetch3", 32'(state), 32'd1);
        chk("lw_irw", 32'({ir_write, bus_err}), 32'(2'b10));
        cyc();
        chk("lw_decode", 32'(state), 32'd2);
        cyc();
        chk("lw_execi", 32'(state), 32'd4);
        chk("lw_execi_alu", 32'(alu_sel), 32'(6'b01_10_10));
        cyc();
        chk("lw_wb", 32'(state), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback states over a single shared instruction/data memory port. Each cycle it drives the mux selects, write enables and ALU operation class for the shared ALU, register file, PC and IR. A watchdog aborts memory accesses that never complete.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles per memory access before abort. Legal range 2..255.
- `CNT_W`, default 8: watchdog counter width. Must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0]. Valid from DECODE onward and stable until the next FETCH.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the access in this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: access is a write.
- `iord` out 1: address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR; the datapath also latches OldPC.
- `pc_write` out 1: load PC.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = rs1, 10 = OldPC.
- `alu_src_b` out 2: ALU B select. 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = add, 01 = subtract/compare, 10 = decode funct.
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 2: writeback source. 00 = ALUOut, 01 = memory data, 10 = PC.
- `instr_done` out 1: one-cycle pulse on instruction retire.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `bus_err` out 1: sticky watchdog abort flag.
- `state` out 4: current state, for debug.

## Operation
- State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JAL=11, JALR=12, ERR=13.
- Outputs not listed for a state are 0.
- BOOT: all outputs 0. Next state FETCH.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00, so the branch/JAL target is captured in ALUOut. Dispatch on `opcode`:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → ADDR
  - 1100011 → BRANCH
  - any other opcode: `illegal_op`=1, next state FETCH, no architectural write.
- EXEC_R: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10. Next state WB_ALU.
- EXEC_I: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=10. Next state WB_ALU.
- ADDR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_req`=1, `iord`=1. On `mem_ready` go to WB_MEM.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready`: `instr_done`=1, next state FETCH.
- WB_ALU: `reg_write`=1, `mem_to_reg`=00, `instr_done`=1. Next state FETCH.
- WB_MEM: `reg_write`=1, `mem_to_reg`=01, `instr_done`=1. Next state FETCH.
- BRANCH: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `instr_done`=1.
  - `pc_write`=`zero`, `pc_src`=01.
  - Next state FETCH.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - Counter clears on entry to a wait state and on `mem_ready`.
  - It increments on each cycle with `mem_req`=1 and `mem_ready`=0.
  - If `mem_ready` is still low on the cycle the count equals `TIMEOUT_CYCLES`-1, the next state is ERR.
  - `mem_ready` in that same cycle wins: the access completes normally.
- ERR: all outputs 0 except `bus_err`=1. Remains in ERR until `rst_n` is asserted.

## Timing
- State is registered. Outputs are a combinational decode of state, `opcode`, `zero` and `mem_ready` (Mealy only for the completion strobes).
- Reset (`rst_n` low): state=BOOT immediately, so every output is 0 asynchronously, including `bus_err`. The first FETCH is the second rising edge after release.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first cycle):
  - R-type / I-type ALU: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL / JALR: 3 (only with the macro below)
- Each memory wait cycle adds 1.
- `mem_req` holds steady until `mem_ready` or abort. The memory must not see `mem_req` drop mid-access except on abort or reset.
- Reset mid-access drops `mem_req` asynchronously; no write completes.

## Configuration
- `MC_CTRL_JUMP_EN`: when defined, DECODE also dispatches 1101111 → JAL and 1100111 → JALR.
  - JAL: `reg_write`=1, `mem_to_reg`=10, `pc_write`=1, `pc_src`=01, `instr_done`=1. Next state FETCH.
  - JALR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `pc_write`=1, `pc_src`=00, `reg_write`=1, `mem_to_reg`=10, `instr_done`=1. Next state FETCH.
- When undefined: both opcodes raise `illegal_op`, and state encodings 11 and 12 are unreachable.

## Test plan
- Release reset, `mem_ready`=1, `opcode`=0110011 → `state` sequence 0,1,2,3,8,1; `reg_write` high only in state 8; `instr_done` pulses once.
- Load with `mem_ready` low for 3 cycles in MEM_RD → 8 cycles total; `iord`=1 and `mem_req` continuous through the wait; then WB_MEM with `mem_to_reg`=01.
- Branch, `zero`=1 then `zero`=0 → `pc_write`=1/`pc_src`=01 in the first case; `pc_write`=0 in the second; 3 cycles each.
- `opcode`=1111111 → `illegal_op` 1-cycle pulse in DECODE, return to FETCH, no `reg_write`/`pc_write`/`mem_we`.
- `TIMEOUT_CYCLES`=4 with `mem_ready` held 0 in FETCH → ERR after 4 FETCH cycles, `bus_err`=1 sticky. Repeat with `mem_ready`=1 on the 4th cycle → normal DECODE, no error.
- Assert `rst_n` low mid-MEM_WR → `mem_req`/`mem_we` drop asynchronously, `state`=0; `opcode`=1101111 decodes to JAL with the macro defined and raises `illegal_op` without it.
